// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing controller: FSM state encoding,
// ALU operation encodings and operation-class helpers.
package alu_share_pkg;

    localparam int ALU_OP_W = 6;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // ALU operation encodings
    localparam logic [ALU_OP_W-1:0] ALUOP_ADD  = 6'd0;
    localparam logic [ALU_OP_W-1:0] ALUOP_SUB  = 6'd1;
    localparam logic [ALU_OP_W-1:0] ALUOP_AND  = 6'd2;
    localparam logic [ALU_OP_W-1:0] ALUOP_OR   = 6'd3;
    localparam logic [ALU_OP_W-1:0] ALUOP_XOR  = 6'd4;
    localparam logic [ALU_OP_W-1:0] ALUOP_NOR  = 6'd5;
    localparam logic [ALU_OP_W-1:0] ALUOP_SLT  = 6'd6;
    localparam logic [ALU_OP_W-1:0] ALUOP_SLTU = 6'd7;
    localparam logic [ALU_OP_W-1:0] ALUOP_SLL  = 6'd8;
    localparam logic [ALU_OP_W-1:0] ALUOP_SRL  = 6'd9;
    localparam logic [ALU_OP_W-1:0] ALUOP_SRA  = 6'd10;
    localparam logic [ALU_OP_W-1:0] ALUOP_LUI  = 6'd11;
    localparam logic [ALU_OP_W-1:0] ALUOP_BEQ  = 6'd16;
    localparam logic [ALU_OP_W-1:0] ALUOP_BNE  = 6'd17;
    localparam logic [ALU_OP_W-1:0] ALUOP_BGEZ = 6'd18;
    localparam logic [ALU_OP_W-1:0] ALUOP_BGTZ = 6'd19;
    localparam logic [ALU_OP_W-1:0] ALUOP_BLEZ = 6'd20;
    localparam logic [ALU_OP_W-1:0] ALUOP_BLTZ = 6'd21;

    // Branch compares: result lives only in the zero flag
    function automatic logic is_cmp_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALUOP_BEQ)  || (op == ALUOP_BNE)  || (op == ALUOP_BGEZ) ||
               (op == ALUOP_BGTZ) || (op == ALUOP_BLEZ) || (op == ALUOP_BLTZ);
    endfunction

    // Set-less-than: result valid on both data and zero flag
    function automatic logic is_slt_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALUOP_SLT) || (op == ALUOP_SLTU);
    endfunction

endpackage

// File: rtl/alu_share_grant.sv
// Two-way grant for the ALU sharing controller.
// ALU_SHARE_RR_EN defined: round-robin between simultaneous requesters.
// ALU_SHARE_RR_EN undefined: fixed priority, requester 0 always wins.
module alu_share_grant (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid_i,
    input  logic req1_valid_i,
    input  logic accept_i,
    output logic grant_o
);

`ifdef ALU_SHARE_RR_EN
    logic last_grant_q;
    logic last_grant_d;

    // Pick the requester that was not served last when both ask
    always_comb begin
        grant_o = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_o = ~last_grant_q;
        end else if (req1_valid_i) begin
            grant_o = 1'b1;
        end
    end

    // Remember the winner of every accepted request
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept_i) begin
            last_grant_d = grant_o;
        end
    end

    // last_grant starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    logic unused_rr_inputs;

    // Fixed priority: requester 1 only when requester 0 is idle
    always_comb begin
        grant_o = ~req0_valid_i & req1_valid_i;
    end

    assign unused_rr_inputs = ^{clk, rst, accept_i};
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two valid/ready requesters.
// Flow per op: IDLE (accept) -> EXEC (drive ALU, capture) -> RESP (hold result).
// Optional macro ALU_SHARE_RR_EN selects round-robin arbitration in alu_share_grant.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = ALU_OP_W,
    parameter int SHAMT_W = 5,
    parameter int ZERO_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [OP_W-1:0]    req0_aluop_i,
    input  logic [DATA_W-1:0]  req0_src0_i,
    input  logic [DATA_W-1:0]  req0_src1_i,
    input  logic [SHAMT_W-1:0] req0_shamt_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [OP_W-1:0]    req1_aluop_i,
    input  logic [DATA_W-1:0]  req1_src0_i,
    input  logic [DATA_W-1:0]  req1_src1_i,
    input  logic [SHAMT_W-1:0] req1_shamt_i,
    output logic               resp0_valid_o,
    input  logic               resp0_ready_i,
    output logic [DATA_W-1:0]  resp0_data_o,
    output logic [ZERO_W-1:0]  resp0_zero_o,
    output logic               resp1_valid_o,
    input  logic               resp1_ready_i,
    output logic [DATA_W-1:0]  resp1_data_o,
    output logic [ZERO_W-1:0]  resp1_zero_o,
    output logic [OP_W-1:0]    alu_aluop_o,
    output logic [DATA_W-1:0]  alu_src0_o,
    output logic [DATA_W-1:0]  alu_src1_o,
    output logic [SHAMT_W-1:0] alu_shamt_o,
    input  logic [DATA_W-1:0]  alu_aluout_i,
    input  logic [ZERO_W-1:0]  alu_zero_i
);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  src0_q, src0_d;
    logic [DATA_W-1:0]  src1_q, src1_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ZERO_W-1:0]  zero_q, zero_d;
    logic               grant;
    logic               accept;

    alu_share_grant u_grant (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (req0_valid_i),
        .req1_valid_i (req1_valid_i),
        .accept_i     (accept),
        .grant_o      (grant)
    );

    // Both responders see the same captured result; only the owner's valid rises
    assign resp0_data_o = data_q;
    assign resp0_zero_o = zero_q;
    assign resp1_data_o = data_q;
    assign resp1_zero_o = zero_q;

    // FSM next state, operand/result capture and all handshake/ALU outputs
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        op_d          = op_q;
        src0_d        = src0_q;
        src1_d        = src1_q;
        shamt_d       = shamt_q;
        data_d        = data_q;
        zero_d        = zero_q;
        accept        = 1'b0;
        req0_ready_o  = 1'b0;
        req1_ready_o  = 1'b0;
        resp0_valid_o = 1'b0;
        resp1_valid_o = 1'b0;
        alu_aluop_o   = '0;
        alu_src0_o    = '0;
        alu_src1_o    = '0;
        alu_shamt_o   = '0;

        unique case (state_q)
            ST_IDLE: begin
                // A flush in IDLE simply suppresses acceptance for that cycle
                if (!flush_i) begin
                    req0_ready_o = ~grant & req0_valid_i;
                    req1_ready_o = grant & req1_valid_i;
                end
                if (req0_ready_o || req1_ready_o) begin
                    accept  = 1'b1;
                    owner_d = grant;
                    state_d = ST_EXEC;
                    if (grant) begin
                        op_d    = req1_aluop_i;
                        src0_d  = req1_src0_i;
                        src1_d  = req1_src1_i;
                        shamt_d = req1_shamt_i;
                    end else begin
                        op_d    = req0_aluop_i;
                        src0_d  = req0_src0_i;
                        src1_d  = req0_src1_i;
                        shamt_d = req0_shamt_i;
                    end
                end
            end
            ST_EXEC: begin
                alu_aluop_o = op_q;
                alu_src0_o  = src0_q;
                alu_src1_o  = src1_q;
                alu_shamt_o = shamt_q;
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                    // The ALU leaves stale values on fields an op does not define
                    if (is_cmp_op(op_q)) begin
                        data_d = '0;
                        zero_d = alu_zero_i;
                    end else if (is_slt_op(op_q)) begin
                        data_d = alu_aluout_i;
                        zero_d = alu_zero_i;
                    end else begin
                        data_d = alu_aluout_i;
                        zero_d = '0;
                    end
                end
            end
            ST_RESP: begin
                resp0_valid_o = ~owner_q;
                resp1_valid_o = owner_q;
                // Flush wins over a same-cycle response handshake
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (owner_q ? resp1_ready_i : resp0_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers; async reset clears all of them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            op_q    <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            shamt_q <= '0;
            data_q  <= '0;
            zero_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            shamt_q <= shamt_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

endmodule
